jk_ff_checker: RTL and testbench

Synthesizable in-circuit checker for a bank of JK flip-flops: it observes the same clock, reset, J, K and Q that a stimulus driver and the flip-flop exchange. It keeps a reference model of every flip-flop, compares each observed Q against the model on every cycle, and reports mismatches through a sticky flag, saturating counters and a first-failure capture. It sits beside the flip-flop bank in the bench or on-chip, replacing $monitor-style eyeballing with a pass/fail result.

---
 rtl/jk_ff_checker.sv | 145 ++++++++++++++
 tb/tb_jk_ff_checker.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_ff_checker.sv
// jk_ff_checker: in-circuit reference checker for a bank of JK flip-flops.
// Mirrors every lane, compares the observed Q each checked cycle, and logs failures.
module jk_ff_checker #(
  parameter  int N      = 1,
  parameter  int CNT_W  = 16,
  localparam int LANE_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              dut_rst,
  input  logic [N-1:0]      j,
  input  logic [N-1:0]      k,
  input  logic [N-1:0]      q,
  output logic              err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  chk_cnt,
  output logic [LANE_W-1:0] first_lane,
  output logic              first_exp,
  output logic              synced
);

  localparam int               PC_W    = $clog2(N + 1);
  localparam int               SUM_W   = CNT_W + PC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    UNSYNC  = 2'd0,
    RSTSEEN = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t            state;
  logic [N-1:0]      model;
  logic [N-1:0]      model_next;
  logic [N-1:0]      mm;
  logic [PC_W-1:0]   mm_cnt;
  logic [LANE_W-1:0] mm_low;
  logic              mm_exp;
  logic [SUM_W-1:0]  err_sum;
  logic [CNT_W-1:0]  err_next;
  logic [CNT_W-1:0]  chk_next;
  logic              compare;

  // Next value of each reference flip-flop; dut_rst wins over J/K.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    model_next = model;
    for (int i = 0; i < N; i++) begin
      case ({j[i], k[i]})
        2'b00:   model_next[i] = model[i];
        2'b01:   model_next[i] = 1'b0;
        2'b10:   model_next[i] = 1'b1;
        default: model_next[i] = ~model[i];
      endcase
    end
    if (dut_rst) model_next = '0;
  end

  // Mismatch vector, its popcount, and the lowest failing lane with its expected value.
  always_comb begin
    mm     = '0;
    mm_cnt = '0;
    mm_low = '0;
    mm_exp = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      // An X/Z on q makes the equality unknown, so the else branch flags it as a mismatch.
      if ((q[i] ^ model[i]) == 1'b0) mm[i] = 1'b0;
      else                           mm[i] = 1'b1;
      if (mm[i]) begin
        mm_cnt = mm_cnt + PC_W'(1);
        mm_low = LANE_W'(i);
        mm_exp = model[i];
      end
    end
  end

  always_comb begin
    compare  = (state == CHECK) && !dut_rst;
    err_sum  = SUM_W'(err_cnt) + SUM_W'(mm_cnt);
    err_next = (err_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : err_sum[CNT_W-1:0];
    chk_next = (chk_cnt == CNT_MAX) ? chk_cnt : chk_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      // NOTE: the model bank is reset deliberately; it must start from the DUT's known reset value.
      model      <= '0;
      state      <= UNSYNC;
      synced     <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
      chk_cnt    <= '0;
      first_lane <= '0;
      first_exp  <= 1'b0;
    end else begin
      model <= model_next;

      case (state)
        UNSYNC: begin
          if (dut_rst) state <= RSTSEEN;
          synced <= 1'b0;
        end
        RSTSEEN: begin
          if (!dut_rst) begin
            state  <= CHECK;
            synced <= 1'b1;
          end else begin
            synced <= 1'b0;
          end
        end
        CHECK: begin
          if (dut_rst) begin
            state  <= RSTSEEN;
            synced <= 1'b0;
          end else begin
            synced <= 1'b1;
          end
        end
        default: begin
          state  <= UNSYNC;
          synced <= 1'b0;
        end
      endcase

      if (clr) begin
        err        <= 1'b0;
        err_cnt    <= '0;
        chk_cnt    <= '0;
        first_lane <= '0;
        first_exp  <= 1'b0;
      end else if (compare) begin
        chk_cnt <= chk_next;
        err_cnt <= err_next;
        if ((|mm) && !err) begin
          err        <= 1'b1;
          first_lane <= mm_low;
          first_exp  <= mm_exp;
        end
      end
    end
  end

endmodule

// File: tb/tb_jk_ff_checker.sv
// Bench for jk_ff_checker: an ideal JK bank with fault injection drives two checkers
// (4 lanes / 8-bit counters and 1 lane / 3-bit counters); a scoreboard compares every cycle.
module tb_jk_ff_checker;

  localparam int N     = 4;
  localparam int CNT_W = 8;
  localparam int SAT_W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, clr, dut_rst;
  logic [N-1:0] j, k, q;

  logic             err, first_exp, synced;
  logic [CNT_W-1:0] err_cnt, chk_cnt;
  logic [1:0]       first_lane;

  logic             s_err, s_first_exp, s_synced;
  logic [SAT_W-1:0] s_err_cnt, s_chk_cnt;
  logic [0:0]       s_first_lane;

  jk_ff_checker #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .dut_rst(dut_rst),
    .j(j), .k(k), .q(q),
    .err(err), .err_cnt(err_cnt), .chk_cnt(chk_cnt),
    .first_lane(first_lane), .first_exp(first_exp), .synced(synced)
  );

  jk_ff_checker #(.N(1), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst(rst), .clr(clr), .dut_rst(dut_rst),
    .j(j[0:0]), .k(k[0:0]), .q(q[0:0]),
    .err(s_err), .err_cnt(s_err_cnt), .chk_cnt(s_chk_cnt),
    .first_lane(s_first_lane), .first_exp(s_first_exp), .synced(s_synced)
  );

  typedef struct {
    int phase;  // 0 = not synced, 1 = waiting out dut_rst, 2 = checking
    int err, err_cnt, chk_cnt, first_lane, first_exp;
  } ref_t;

  typedef struct {
    ref_t m;
    ref_t s;
  } exp_t;

  exp_t sb[$];
  ref_t rm, rs;
  bit   shadow[N];  // what the checker should believe each Q is
  bit   bank[N];    // the ideal flip-flop bank being observed
  logic [N-1:0] stuck0, flip, once;
  bit   force0;
  int   n_checks = 0, n_fail = 0, n_push = 0, n_pop = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ref_t ref_step(ref_t r, int nl, int maxv);
    int miss;
    int low;
    bit cmp;
    miss = 0;
    low  = -1;
    cmp  = (r.phase == 2) && !dut_rst;
    for (int i = 0; i < nl; i++)
      if (q[i] !== logic'(shadow[i])) begin
        miss++;
        if (low < 0) low = i;
      end
    if (clr) begin
      r.err = 0; r.err_cnt = 0; r.chk_cnt = 0; r.first_lane = 0; r.first_exp = 0;
    end else if (cmp) begin
      r.chk_cnt = (r.chk_cnt + 1 > maxv) ? maxv : r.chk_cnt + 1;
      r.err_cnt = (r.err_cnt + miss > maxv) ? maxv : r.err_cnt + miss;
      if (miss > 0 && r.err == 0) begin
        r.err = 1; r.first_lane = low; r.first_exp = int'(shadow[low]);
      end
    end
    if (dut_rst)           r.phase = 1;
    else if (r.phase == 1) r.phase = 2;
    return r;
  endfunction

  function automatic bit jk_next(bit cur, logic jj, logic kk);
    if (jj && kk) return !cur;
    if (jj)       return 1'b1;
    if (kk)       return 1'b0;
    return cur;
  endfunction

  // Called right after each rising edge with the inputs the DUTs just sampled.
  task automatic model_edge();
    exp_t e;
    if (rst) begin
      rm = '{default: 0};
      rs = '{default: 0};
      foreach (shadow[i]) shadow[i] = 1'b0;
    end else begin
      rm = ref_step(rm, N, (1 << CNT_W) - 1);
      rs = ref_step(rs, 1, (1 << SAT_W) - 1);
      foreach (shadow[i]) shadow[i] = dut_rst ? 1'b0 : jk_next(shadow[i], j[i], k[i]);
    end
    foreach (bank[i]) bank[i] = dut_rst ? 1'b0 : jk_next(bank[i], j[i], k[i]);
    e.m = rm;
    e.s = rs;
    sb.push_back(e);
    n_push++;
  endtask

  task automatic step(bit r, bit c, bit dr, logic [N-1:0] jj, logic [N-1:0] kk);
    logic [N-1:0] qv;
    @(negedge clk);
    rst = r; clr = c; dut_rst = dr; j = jj; k = kk;
    for (int i = 0; i < N; i++) qv[i] = stuck0[i] ? 1'b0 : (bank[i] ^ flip[i] ^ once[i]);
    if (force0 && bank[0]) begin
      qv[0]  = 1'b0;
      force0 = 1'b0;
    end
    once = '0;
    q = qv;
    @(posedge clk);
    model_edge();
  endtask

  task automatic rstep(bit r, bit c, bit dr);
    step(r, c, dr, N'($urandom), N'($urandom));
  endtask

  // Monitor: every falling edge, pop the expectation for the last rising edge.
  exp_t mon_e;
  initial forever begin
    @(negedge clk);
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_pop++;
      check("err",        err,          mon_e.m.err);
      check("err_cnt",    err_cnt,      mon_e.m.err_cnt);
      check("chk_cnt",    chk_cnt,      mon_e.m.chk_cnt);
      check("first_lane", first_lane,   mon_e.m.first_lane);
      check("first_exp",  first_exp,    mon_e.m.first_exp);
      check("synced",     synced,       mon_e.m.phase == 2);
      check("s_err",      s_err,        mon_e.s.err);
      check("s_err_cnt",  s_err_cnt,    mon_e.s.err_cnt);
      check("s_chk_cnt",  s_chk_cnt,    mon_e.s.chk_cnt);
      check("s_first",    s_first_exp,  mon_e.s.first_exp);
      check("s_synced",   s_synced,     mon_e.s.phase == 2);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [1:0] gseq [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11};

  initial begin
    rst = 1'b1; clr = 1'b0; dut_rst = 1'b0; j = '0; k = '0; q = '0;
    stuck0 = '0; flip = '0; once = '0; force0 = 1'b0;
    rm = '{default: 0};
    rs = '{default: 0};
    foreach (bank[i]) begin bank[i] = 1'b0; shadow[i] = 1'b0; end

    step(1, 0, 0, '0, '0);
    step(1, 0, 0, '0, '0);

    // Golden sequence with a correct bank.
    step(0, 0, 1, '0, '0);
    step(0, 0, 1, '0, '0);
    for (int s = 0; s < 9; s++) begin
      logic [1:0] jk;
      jk = (s < 8) ? gseq[s] : 2'b00;
      step(0, 0, 0, {N{jk[1]}}, {N{jk[0]}});
    end
    #1;
    check("golden_chk_cnt", chk_cnt, 8);
    check("golden_err", err, 0);

    // Single fault: the first 1 on lane 0 is read back as 0.
    step(0, 1, 1, '0, '0);
    step(0, 0, 1, '0, '0);
    force0 = 1'b1;
    for (int s = 0; s < 9; s++) begin
      logic [1:0] jk;
      jk = (s < 8) ? gseq[s] : 2'b00;
      step(0, 0, 0, {N{jk[1]}}, {N{jk[0]}});
      #1;
      check("fault_latency", err, s >= 3);
    end
    check("fault_err_cnt", err_cnt, 1);
    check("fault_lane", first_lane, 0);
    check("fault_exp", first_exp, 1);

    // Lanes 1 and 3 stuck at 0, every lane set.
    stuck0 = 4'b1010;
    step(0, 1, 0, '1, '0);
    repeat (4) step(0, 0, 0, '1, '0);
    #1;
    check("multi_err_cnt", err_cnt, 8);
    check("multi_chk_cnt", chk_cnt, 4);
    check("multi_lane", first_lane, 1);
    check("multi_exp", first_exp, 1);

    // Mid-run DUT reset: one skipped compare, then a clean restart.
    stuck0 = '0;
    rstep(0, 1, 0);
    repeat (4) rstep(0, 0, 0);
    step(0, 0, 1, '0, '0);
    #1;
    check("midrst_synced_low", synced, 0);
    check("midrst_chk_hold", chk_cnt, 4);
    rstep(0, 0, 0);
    #1;
    check("midrst_synced_high", synced, 1);
    repeat (20) rstep(0, 0, 0);
    #1;
    check("midrst_no_err", err_cnt, 0);

    // Persistent fault on lane 0 for 10 compares.
    flip = 4'b0001;
    rstep(0, 1, 0);
    repeat (10) rstep(0, 0, 0);
    #1;
    check("sat_err_cnt", s_err_cnt, 7);
    check("sat_chk_cnt", s_chk_cnt, 7);
    check("wide_err_cnt", err_cnt, 10);

    // clr while err is set.
    rstep(0, 1, 0);
    #1;
    check("clr_err", err, 0);
    check("clr_err_cnt", err_cnt, 0);
    check("clr_chk_cnt", chk_cnt, 0);
    check("clr_synced", synced, 1);

    // rst with clr: no compares until a fresh dut_rst pulse.
    rstep(1, 1, 0);
    repeat (5) rstep(0, 0, 0);
    #1;
    check("rstclr_chk_cnt", chk_cnt, 0);
    check("rstclr_synced", synced, 0);
    step(0, 0, 1, '0, '0);
    rstep(0, 0, 0);
    rstep(0, 0, 0);
    #1;
    check("resync_chk_cnt", chk_cnt, 1);
    check("resync_err", err, 1);

    // Random traffic with sporadic resets, clears and one-shot faults.
    flip = '0;
    rstep(0, 1, 0);
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 14) == 0) once = N'(1 << $urandom_range(0, N - 1));
      rstep($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 19) == 0);
    end

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    #1;
    check("drain", sb.size(), 0);
    check("push_pop", n_pop, n_push);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
